// File: rtl/acc_readout_arbiter_if.sv
// Bundle between the accumulator channels, the readout arbiter and the serializer.
// The slave modport is the arbiter side; the master modport drives channels and serializer ready.
interface acc_readout_arbiter_if #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned ACC_WIDTH   = 16,
  parameter int unsigned CH_ID_WIDTH = 2
);
  logic [NUM_CH-1:0]           chValid;
  logic [NUM_CH*ACC_WIDTH-1:0] chData_I;
  logic [NUM_CH*ACC_WIDTH-1:0] chData_Q;
  logic                        outReady;
  logic                        clearOverflow;
  logic                        outValid;
  logic [ACC_WIDTH-1:0]        outData_I;
  logic [ACC_WIDTH-1:0]        outData_Q;
  logic [CH_ID_WIDTH-1:0]      outChannel;
  logic [NUM_CH-1:0]           overflow;
  logic                        busy;

  modport master (
    output chValid, chData_I, chData_Q, outReady, clearOverflow,
    input  outValid, outData_I, outData_Q, outChannel, overflow, busy
  );

  modport slave (
    input  chValid, chData_I, chData_Q, outReady, clearOverflow,
    output outValid, outData_I, outData_Q, outChannel, overflow, busy
  );
endinterface

// File: rtl/acc_readout_arbiter.sv
// Per-channel I/Q holding slots with a round-robin grant into one registered output word pair.
// Results arriving at an occupied, non-granted slot are dropped and flagged in a sticky overflow.
module acc_readout_arbiter #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned ACC_WIDTH   = 16,
  parameter int unsigned CH_ID_WIDTH = 2
) (
  input logic                  clk,
  input logic                  reset,
  acc_readout_arbiter_if.slave bus
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   slot_i_q [NUM_CH];
  logic [ACC_WIDTH-1:0]   slot_i_d [NUM_CH];
  logic [ACC_WIDTH-1:0]   slot_q_q [NUM_CH];
  logic [ACC_WIDTH-1:0]   slot_q_d [NUM_CH];
  logic [NUM_CH-1:0]      pending_q, pending_d;
  logic [NUM_CH-1:0]      overflow_q, overflow_d;
  logic [CH_ID_WIDTH-1:0] last_grant_q, last_grant_d;
  logic [ACC_WIDTH-1:0]   out_i_q, out_i_d;
  logic [ACC_WIDTH-1:0]   out_q_q, out_q_d;
  logic [CH_ID_WIDTH-1:0] out_ch_q, out_ch_d;
  logic                   busy_q, busy_d;

  logic                   grant_found;
  logic [CH_ID_WIDTH-1:0] grant_idx;
  logic [CH_ID_WIDTH-1:0] cand;
  logic                   load;
  logic [NUM_CH-1:0]      grant_oh;
  logic [NUM_CH-1:0]      capture;
  logic [NUM_CH-1:0]      drop;

  // Round-robin search over registered pending bits, starting just after the last grant.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      cand = CH_ID_WIDTH'((32'(last_grant_q) + i) % NUM_CH);
      if (!grant_found && pending_q[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign load = grant_found && ((state_q == StEmpty) || bus.outReady);

  always_comb begin
    state_d      = state_q;
    out_i_d      = out_i_q;
    out_q_d      = out_q_q;
    out_ch_d     = out_ch_q;
    last_grant_d = last_grant_q;
    pending_d    = pending_q;
    overflow_d   = overflow_q & ~{NUM_CH{bus.clearOverflow}};
    grant_oh     = '0;
    capture      = '0;
    drop         = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      slot_i_d[k] = slot_i_q[k];
      slot_q_d[k] = slot_q_q[k];
    end

    if (load) begin
      state_d      = StFull;
      out_i_d      = slot_i_q[grant_idx];
      out_q_d      = slot_q_q[grant_idx];
      out_ch_d     = grant_idx;
      last_grant_d = grant_idx;
    end else if ((state_q == StFull) && bus.outReady) begin
      state_d = StEmpty;
    end

    // A slot being granted this cycle is free to accept a new result.
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      grant_oh[k] = load && (grant_idx == CH_ID_WIDTH'(k));
      capture[k]  = bus.chValid[k] && (!pending_q[k] || grant_oh[k]);
      drop[k]     = bus.chValid[k] && pending_q[k] && !grant_oh[k];
      if (capture[k]) begin
        slot_i_d[k]  = bus.chData_I[k*ACC_WIDTH +: ACC_WIDTH];
        slot_q_d[k]  = bus.chData_Q[k*ACC_WIDTH +: ACC_WIDTH];
        pending_d[k] = 1'b1;
      end else if (grant_oh[k]) begin
        pending_d[k] = 1'b0;
      end
      if (drop[k]) begin
        overflow_d[k] = 1'b1;
      end
    end

    busy_d = (|pending_q) || (state_q == StFull);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StEmpty;
      pending_q    <= '0;
      overflow_q   <= '0;
      last_grant_q <= CH_ID_WIDTH'(NUM_CH - 1);
      out_i_q      <= '0;
      out_q_q      <= '0;
      out_ch_q     <= '0;
      busy_q       <= 1'b0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        slot_i_q[k] <= '0;
        slot_q_q[k] <= '0;
      end
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      overflow_q   <= overflow_d;
      last_grant_q <= last_grant_d;
      out_i_q      <= out_i_d;
      out_q_q      <= out_q_d;
      out_ch_q     <= out_ch_d;
      busy_q       <= busy_d;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        slot_i_q[k] <= slot_i_d[k];
        slot_q_q[k] <= slot_q_d[k];
      end
    end
  end

  assign bus.outValid   = (state_q == StFull);
  assign bus.outData_I  = out_i_q;
  assign bus.outData_Q  = out_q_q;
  assign bus.outChannel = out_ch_q;
  assign bus.overflow   = overflow_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_acc_readout_arbiter.sv
// Scoreboard bench for acc_readout_arbiter: expected words are queued when channels fire
// and popped by a monitor whenever the output handshake completes.
module tb_acc_readout_arbiter;

  localparam int unsigned NumCh   = 4;
  localparam int unsigned AccW    = 16;
  localparam int unsigned ChW     = 2;

  typedef struct packed {
    logic [ChW-1:0]  ch;
    logic [AccW-1:0] i;
    logic [AccW-1:0] q;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t sb_q[$];
  exp_t mon_e;

  acc_readout_arbiter_if #(.NUM_CH(NumCh), .ACC_WIDTH(AccW), .CH_ID_WIDTH(ChW)) bus ();

  acc_readout_arbiter #(
    .NUM_CH      (NumCh),
    .ACC_WIDTH   (AccW),
    .CH_ID_WIDTH (ChW)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Handshake sampled mid-cycle, where inputs and outputs are both settled.
  always @(negedge clk) begin
    if (!reset && bus.outValid && bus.outReady) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_out", 32'(bus.outChannel), 32'hFFFF);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_ch", 32'(bus.outChannel), 32'(mon_e.ch));
        check("sb_i",  32'(bus.outData_I),  32'(mon_e.i));
        check("sb_q",  32'(bus.outData_Q),  32'(mon_e.q));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [AccW-1:0] di, input logic [AccW-1:0] dq,
                        input bit expect_out);
    exp_t e;
    bus.chData_I[k*AccW +: AccW] = di;
    bus.chData_Q[k*AccW +: AccW] = dq;
    if (expect_out) begin
      e.ch = ChW'(k);
      e.i  = di;
      e.q  = dq;
      sb_q.push_back(e);
    end
  endtask

  task automatic pulse(input logic [NumCh-1:0] v);
    bus.chValid = v;
    tick();
    bus.chValid = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    sb_q.delete();
  endtask

  task automatic wait_idle();
    int n;
    tick();
    tick();
    n = 0;
    while ((bus.busy || bus.outValid || sb_q.size() != 0) && n < 60) begin
      tick();
      n++;
    end
    if (n >= 60) check("idle_timeout", 32'(n), 32'd0);
  endtask

  initial begin
    checks            = 0;
    errors            = 0;
    reset             = 1'b1;
    bus.chValid       = '0;
    bus.chData_I      = '0;
    bus.chData_Q      = '0;
    bus.outReady      = 1'b0;
    bus.clearOverflow = 1'b0;
    do_reset();

    check("rst_valid",    32'(bus.outValid),   32'd0);
    check("rst_data_i",   32'(bus.outData_I),  32'd0);
    check("rst_data_q",   32'(bus.outData_Q),  32'd0);
    check("rst_channel",  32'(bus.outChannel), 32'd0);
    check("rst_overflow", 32'(bus.overflow),   32'd0);
    check("rst_busy",     32'(bus.busy),       32'd0);

    // Single result: two-cycle latency, one valid cycle.
    bus.outReady = 1'b1;
    set_ch(0, 16'h1234, 16'hABCD, 1'b1);
    pulse(4'b0001);
    check("single_t1_valid", 32'(bus.outValid), 32'd0);
    tick();
    check("single_t2_valid", 32'(bus.outValid), 32'd1);
    check("single_t2_ch",    32'(bus.outChannel), 32'd0);
    tick();
    check("single_t3_valid", 32'(bus.outValid), 32'd0);
    check("single_overflow", 32'(bus.overflow), 32'd0);
    wait_idle();

    // Simultaneous arrival from reset priority: 0,1,2,3 back to back.
    do_reset();
    bus.outReady = 1'b1;
    for (int k = 0; k < 4; k++) set_ch(k, AccW'(16'h1000 + k), AccW'(16'h2000 + k), 1'b1);
    pulse(4'b1111);
    tick();
    for (int k = 0; k < 4; k++) begin
      check("burst_valid", 32'(bus.outValid), 32'd1);
      check("burst_ch",    32'(bus.outChannel), 32'(k));
      tick();
    end
    check("burst_end_valid", 32'(bus.outValid), 32'd0);
    tick();
    check("burst_end_busy", 32'(bus.busy), 32'd0);

    // Fairness: after granting 2, channels 1 and 3 go 3 then 1.
    set_ch(2, 16'h0202, 16'h2020, 1'b1);
    pulse(4'b0100);
    wait_idle();
    set_ch(1, 16'h0101, 16'h1010, 1'b0);
    set_ch(3, 16'h0303, 16'h3030, 1'b1);
    set_ch(1, 16'h0101, 16'h1010, 1'b1);
    pulse(4'b1010);
    tick();
    check("wrap_first_ch", 32'(bus.outChannel), 32'd3);
    tick();
    check("wrap_second_ch", 32'(bus.outChannel), 32'd1);
    wait_idle();

    // Backpressure: channel 1 held at the output for 10 cycles.
    do_reset();
    bus.outReady = 1'b0;
    set_ch(1, 16'h5A5A, 16'hA5A5, 1'b1);
    set_ch(2, 16'h7777, 16'h8888, 1'b1);
    pulse(4'b0110);
    tick();
    for (int n = 0; n < 10; n++) begin
      check("bp_valid", 32'(bus.outValid), 32'd1);
      check("bp_ch",    32'(bus.outChannel), 32'd1);
      check("bp_i",     32'(bus.outData_I), 32'h5A5A);
      tick();
    end
    bus.outReady = 1'b1;
    tick();
    check("bp_next_valid", 32'(bus.outValid), 32'd1);
    check("bp_next_ch",    32'(bus.outChannel), 32'd2);
    wait_idle();

    // Overflow: slot 2 occupied while channel 0 blocks the output.
    do_reset();
    bus.outReady = 1'b0;
    set_ch(0, 16'hC0C0, 16'h0C0C, 1'b1);
    pulse(4'b0001);
    set_ch(2, 16'hD2A0, 16'h2AD0, 1'b1);
    pulse(4'b0100);
    check("ovf_none_yet", 32'(bus.overflow), 32'd0);
    set_ch(2, 16'hD2B0, 16'h2BD0, 1'b0);
    pulse(4'b0100);
    set_ch(2, 16'hD2C0, 16'h2CD0, 1'b0);
    pulse(4'b0100);
    check("ovf_set", 32'(bus.overflow), 32'b0100);
    bus.clearOverflow = 1'b1;
    tick();
    bus.clearOverflow = 1'b0;
    check("ovf_clear", 32'(bus.overflow), 32'd0);
    bus.clearOverflow = 1'b1;
    pulse(4'b0100);
    bus.clearOverflow = 1'b0;
    check("ovf_set_wins", 32'(bus.overflow), 32'b0100);
    bus.outReady = 1'b1;
    wait_idle();
    check("ovf_sticky", 32'(bus.overflow), 32'b0100);

    // Reset mid-transfer discards output and slots; channel 0 regains priority.
    bus.outReady = 1'b0;
    set_ch(1, 16'h1111, 16'h1111, 1'b0);
    set_ch(2, 16'h2222, 16'h2222, 1'b0);
    pulse(4'b0110);
    tick();
    check("mid_pre_valid", 32'(bus.outValid), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb_q.delete();
    check("mid_valid",    32'(bus.outValid),   32'd0);
    check("mid_data_i",   32'(bus.outData_I),  32'd0);
    check("mid_channel",  32'(bus.outChannel), 32'd0);
    check("mid_overflow", 32'(bus.overflow),   32'd0);
    check("mid_busy",     32'(bus.busy),       32'd0);
    for (int n = 0; n < 4; n++) begin
      tick();
      check("mid_no_grant", 32'(bus.outValid), 32'd0);
    end
    bus.outReady = 1'b1;
    set_ch(0, 16'hF000, 16'h000F, 1'b1);
    set_ch(3, 16'hF003, 16'h300F, 1'b1);
    pulse(4'b1001);
    tick();
    check("mid_prio_ch", 32'(bus.outChannel), 32'd0);
    wait_idle();
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
